out_buf: RTL and testbench

OUT_BUF -- requirements
Module: out_buf

---
 rtl/out_buf.sv | 105 ++++++++++
 tb/tb_out_buf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/out_buf.sv
// Double-buffered result store: out_ctrl fills one bank word by word while
// batch_ctrl drains the other in 2-word beats; banks hand off strictly alternately.
module out_buf #(
  parameter int DW = 32,
  parameter int NW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_stall,
  output logic            s_fin,
  input  logic            rd_v,
  input  logic [2:0]      rd_a,
  output logic [2*DW-1:0] rd_data,
  output logic            ovf
);

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_t;
  typedef enum logic [1:0] {R_IDLE, R_ARM, R_DRAIN} rd_t;

  bank_t       bst   [2];
  bank_t       bst_n [2];
  rd_t         rstate, rstate_n;
  logic        wb, rb;
  logic [3:0]  wcnt;
  logic [2:0]  rcnt;
  logic [DW-1:0] mem [2][NW];

  logic clr, wr_acc, fill_done, arm, beat, drain_done;

  assign clr       = reset | ~run;
  assign wr_stall  = (bst[wb] == B_FULL) || (bst[wb] == B_DRAIN);
  assign wr_acc    = wr_en & ~wr_stall;
  assign fill_done = wr_acc & (wcnt == 4'hf);

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (clr) rstate <= R_IDLE;
    else     rstate <= rstate_n;
  end

  // Read FSM: next state
  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE:  if (bst[rb] == B_FULL) rstate_n = R_ARM;
      R_ARM:   rstate_n = R_DRAIN;
      R_DRAIN: if (rd_v && rcnt == 3'd7) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    arm        = (rstate == R_ARM);
    beat       = (rstate == R_DRAIN) & rd_v;
    drain_done = beat & (rcnt == 3'd7);
  end

  // Fill and drain touch different banks, so both updates may land on one edge.
  always_comb begin
    bst_n[0] = bst[0];
    bst_n[1] = bst[1];
    if (wr_acc)     bst_n[wb] = fill_done ? B_FULL : B_FILL;
    if (arm)        bst_n[rb] = B_DRAIN;
    if (drain_done) bst_n[rb] = B_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bst[0]  <= B_EMPTY;
      bst[1]  <= B_EMPTY;
      wb      <= 1'b0;
      rb      <= 1'b0;
      wcnt    <= '0;
      rcnt    <= '0;
      s_fin   <= 1'b0;
      ovf     <= 1'b0;
      rd_data <= '0;
    end else begin
      bst[0] <= bst_n[0];
      bst[1] <= bst_n[1];
      s_fin  <= arm;
      if (wr_en && wr_stall) ovf <= 1'b1;
      if (wr_acc) begin
        wcnt <= fill_done ? 4'd0 : wcnt + 4'd1;
        if (fill_done) wb <= ~wb;
      end
      if (beat) begin
        rcnt    <= drain_done ? 3'd0 : rcnt + 3'd1;
        rd_data <= {mem[rb][{rd_a, 1'b1}], mem[rb][{rd_a, 1'b0}]};
        if (drain_done) rb <= ~rb;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wb][wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_out_buf.sv
// Bench for out_buf: directed scenarios plus random traffic against a
// queue-of-filled-banks reference model, checked every cycle.
module tb_out_buf;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1, run = 1'b0, wr_en = 1'b0, rd_v = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [2:0]    rd_a = '0;
  logic          wr_stall, s_fin, ovf;
  logic [2*DW-1:0] rd_data;

  out_buf #(.DW(DW), .NW(16)) dut (
    .clk(clk), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_stall(wr_stall), .s_fin(s_fin), .rd_v(rd_v),
    .rd_a(rd_a), .rd_data(rd_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, sfin_cnt = 0;

  // Reference model: queue of completed bank ids (head is waiting or draining).
  int          q[$];
  logic [DW-1:0] mm [2][16];
  int          fill_bank = 0, fill_cnt = 0, beats = 0, wait_ct = 0;
  bit          draining = 0;
  logic        exp_sfin = 0, exp_ovf = 0;
  logic [2*DW-1:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pre_full;
    if (reset || !run) begin
      q.delete(); fill_bank = 0; fill_cnt = 0; beats = 0; wait_ct = 0;
      draining = 0; exp_sfin = 0; exp_ovf = 0; exp_rd = '0;
      return;
    end
    pre_full = (q.size() == 2);
    exp_sfin = 0;
    if (draining) begin
      if (rd_v) begin
        exp_rd = {mm[q[0]][int'(rd_a)*2+1], mm[q[0]][int'(rd_a)*2]};
        beats++;
        if (beats == 8) begin
          void'(q.pop_front());
          draining = 0; beats = 0;
          if (q.size() > 0) wait_ct = 2;
        end
      end
    end else if (wait_ct > 0) begin
      wait_ct--;
      if (wait_ct == 0) begin draining = 1; exp_sfin = 1; end
    end
    if (wr_en) begin
      if (pre_full) exp_ovf = 1;
      else begin
        mm[fill_bank][wr_addr] = wr_data;
        fill_cnt++;
        if (fill_cnt == 16) begin
          if (q.size() == 0) wait_ct = 2;
          q.push_back(fill_bank);
          fill_bank ^= 1; fill_cnt = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic we, input logic [3:0] wa,
                      input logic [DW-1:0] wd, input logic rv, input logic [2:0] ra);
    reset = r; run = ru; wr_en = we; wr_addr = wa; wr_data = wd; rd_v = rv; rd_a = ra;
    @(posedge clk);
    model_edge();
    #1;
    if (s_fin === 1'b1) sfin_cnt++;
    chk("wr_stall", {63'd0, wr_stall}, {63'd0, q.size() == 2});
    chk("s_fin", {63'd0, s_fin}, {63'd0, exp_sfin});
    chk("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic cyc(input logic we, input logic [3:0] wa, input logic [DW-1:0] wd,
                     input logic rv, input logic [2:0] ra);
    step(1'b0, 1'b1, we, wa, wd, rv, ra);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    int s0;
    logic [3:0] alist [16];
    // Reset state
    do_reset();
    chk("rst_stall", {63'd0, wr_stall}, 64'd0);
    chk("rst_sfin", {63'd0, s_fin}, 64'd0);
    chk("rst_rd", rd_data, 64'd0);

    // Basic fill, 2-cycle s_fin latency, full drain
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, 4'(i), 32'h100 + i, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b35_sfin_early", {63'd0, s_fin}, 64'd0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b35_sfin", {63'd0, s_fin}, 64'd1);
    for (int unsigned a = 0; a < 8; a++) begin
      cyc(1'b0, '0, '0, 1'b1, 3'(a));
      if (a == 3) chk("b35_beat3", rd_data, {32'h107, 32'h106});
    end
    chk("b35_empty", {63'd0, wr_stall}, 64'd0);

    // 33 writes with no reads: both banks fill, 33rd dropped
    do_reset();
    s0 = sfin_cnt;
    for (int unsigned i = 0; i < 32; i++) cyc(1'b1, 4'(i % 16), $urandom, 1'b0, '0);
    chk("b36_stall", {63'd0, wr_stall}, 64'd1);
    cyc(1'b1, 4'd0, 32'hdead, 1'b0, '0);
    chk("b36_ovf", {63'd0, ovf}, 64'd1);
    for (int unsigned i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b36_sfin_once", 64'(sfin_cnt - s0), 64'd1);

    // B1 fill-complete on the same edge as the last B0 drain beat
    do_reset();
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, 4'(i), 32'h200 + i, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    for (int unsigned i = 0; i < 15; i++) cyc(1'b1, 4'(i), 32'h300 + i, i < 7, 3'(i));
    cyc(1'b1, 4'd15, 32'h30f, 1'b1, 3'd7);
    chk("b37_writable", {63'd0, wr_stall}, 64'd0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b37_sfin", {63'd0, s_fin}, 64'd1);

    // Duplicate address: counts as a write, last value wins
    do_reset();
    for (int unsigned i = 0; i < 16; i++) alist[i] = 4'(i);
    alist[9] = 4'd5;
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, alist[i], 32'h400 + i, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b38_sfin", {63'd0, s_fin}, 64'd1);
    cyc(1'b0, '0, '0, 1'b1, 3'd2);
    chk("b38_word5", {32'd0, rd_data[63:32]}, 64'h409);

    // run low abandons a partial bank
    do_reset();
    for (int unsigned i = 0; i < 10; i++) cyc(1'b1, 4'(i), 32'h500 + i, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    s0 = sfin_cnt;
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, 4'(i), 32'h600 + i, 1'b0, '0);
    for (int unsigned i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, '0);
    chk("b39_sfin_once", 64'(sfin_cnt - s0), 64'd1);
    chk("b39_ovf", {63'd0, ovf}, 64'd0);
    for (int unsigned a = 0; a < 8; a++) cyc(1'b0, '0, '0, 1'b1, 3'(7 - a));
    chk("b39_beat0", rd_data, {32'h601, 32'h600});

    // rd_v while idle is ignored; the next batch still needs all 8 beats
    do_reset();
    for (int unsigned i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1, 3'(i));
    chk("b40_rd_hold", rd_data, 64'd0);
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, 4'(i), 32'h700 + i, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, '0);
    for (int unsigned a = 0; a < 8; a++) cyc(1'b0, '0, '0, 1'b1, 3'(a));

    // Random traffic
    do_reset();
    for (int unsigned n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0)
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      else
        cyc($urandom_range(0, 9) < 6, 4'($urandom), $urandom,
            $urandom_range(0, 9) < 4, 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
